eth_tx_pkt_arbiter: RTL and testbench
=====================================

Name: eth_tx_pkt_arbiter

Overview:
- Packet-atomic arbiter sharing the 64-bit Ethernet MAC TX stream between two sources: CHDR/VITA traffic (port 0) and CPU traffic (port 1).
- Sits between the IPv4/CHDR adapter TX outputs and the MAC.
- Weighted round-robin: CHDR gets up to CHDR_WEIGHT consecutive packets while CPU is waiting, then CPU gets one. This prevents CPU starvation under streaming load.
- Provides drain control, per-port packet counters and a busy/idle status for software.

Parameters:
- CHDR_WEIGHT, 4, max consecutive CHDR packets granted while CPU has a packet pending (legal range 1..15).
- CNT_W, 32, width of per-port packet counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- arb_en  in  1  1 = new grants allowed; 0 = finish the current packet, then hold idle
- s0_tdata  in  64  CHDR packet data
- s0_tuser  in  4  valid-byte count on the last beat (0 = all 8 bytes)
- s0_tlast  in  1  CHDR end of packet
- s0_tvalid  in  1  CHDR valid
- s0_tready  out  1  CHDR ready
- s1_tdata / s1_tuser / s1_tlast / s1_tvalid / s1_tready  same widths and meanings as s0, for the CPU port
- m_tdata  out  64  to MAC
- m_tuser  out  4  to MAC
- m_tlast  out  1  to MAC
- m_tvalid  out  1  to MAC
- m_tready  in  1  from MAC
- idle  out  1  1 when in IDLE state
- pkt_cnt0  out  CNT_W  completed CHDR packets
- pkt_cnt1  out  CNT_W  completed CPU packets

Behaviour:
- Reset values:
  - state = IDLE
  - m_tvalid = 0, s0_tready = 0, s1_tready = 0
  - m_tdata, m_tuser, m_tlast = 0
  - idle = 1
  - pkt_cnt0 = pkt_cnt1 = 0
  - weight counter wcnt = 0
- States: IDLE, PASS0, PASS1.
- IDLE:
  - All s*_tready = 0; m_tvalid = 0; m_tdata/m_tuser/m_tlast driven 0.
  - If arb_en = 1, evaluate grant on this cycle and enter PASSx on the next edge.
  - Exactly one bubble cycle before the first beat of every packet.
- Grant rule (IDLE, arb_en = 1):
  - Only s0_tvalid → PASS0.
  - Only s1_tvalid → PASS1.
  - Both valid → PASS0 if wcnt < CHDR_WEIGHT, else PASS1.
  - Neither valid → stay in IDLE.
- wcnt update:
  - PASS0 grant → wcnt increments, saturating at CHDR_WEIGHT.
  - PASS1 grant → wcnt = 0.
  - wcnt is 4 bits.
- PASSx (combinational pass-through, zero added latency):
  - m_tdata/m_tuser/m_tlast/m_tvalid = sx_*.
  - sx_tready = m_tready.
  - The other port's tready = 0.
- Packet end: a beat with sx_tvalid & m_tready & sx_tlast increments pkt_cntx (wraps at 2^CNT_W) and returns to IDLE on the next edge.
- A source dropping tvalid mid-packet stalls the output; the grant is held until tlast. Packets are never interleaved.
- arb_en changes:
  - Deasserting arb_en mid-packet does not truncate; the packet completes, then the block holds IDLE.
  - Re-asserting arb_en resumes arbitration with wcnt preserved.
- tuser is passed unmodified on all beats and is meaningful on the last beat only.
- idle = 1 exactly when state = IDLE; it is registered alongside state.
- Reset mid-packet:
  - Immediate return to IDLE; the downstream MAC sees a truncated packet.
  - Upstream senders must be reset together with this block.
- Single-beat packets (tlast on the first beat) are legal and take 2 cycles per packet: grant cycle plus data beat.

Test Plan:
- Only CPU traffic: three 5-beat packets, m_tready = 1 → output is 3 packets, 6 cycles per packet (1 bubble + 5 beats), pkt_cnt1 = 3, pkt_cnt0 = 0, data and tuser bit-exact.
- Both ports continuously valid, CHDR_WEIGHT = 4, 2-beat packets → output port order 0,0,0,0,1,0,0,0,0,1…; after 10 packets pkt_cnt0 = 8, pkt_cnt1 = 2.
- Backpressure: m_tready random 50%, CHDR 9-beat packet whose last beat has tuser = 3 → no beat lost or duplicated, s1_tready stays 0 throughout, tuser = 3 appears only with m_tlast.
- s0 deasserts tvalid for 4 cycles mid-packet while s1 is valid → m_tvalid = 0 for 4 cycles, grant not switched, CPU packet follows only after CHDR tlast.
- arb_en dropped on beat 2 of a 6-beat packet → packet completes, idle = 1 afterwards, no new grant despite valid inputs; arb_en = 1 → grant on the next cycle.
- Reset asserted on beat 3 → next cycle: state IDLE, all treadys = 0, m_tvalid = 0, counters = 0, wcnt = 0.

Source files
------------

// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-atomic weighted round-robin arbiter that merges CHDR (port 0) and CPU (port 1)
// AXI-stream traffic onto the 64-bit MAC TX stream, with drain control and packet counters.
`timescale 1ns/1ps
module eth_tx_pkt_arbiter #(
  parameter int CHDR_WEIGHT = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arb_en,
  input  logic [63:0]      s0_tdata,
  input  logic [3:0]       s0_tuser,
  input  logic             s0_tlast,
  input  logic             s0_tvalid,
  output logic             s0_tready,
  input  logic [63:0]      s1_tdata,
  input  logic [3:0]       s1_tuser,
  input  logic             s1_tlast,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  output logic [63:0]      m_tdata,
  output logic [3:0]       m_tuser,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             idle,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  localparam logic [3:0] WMAX = 4'(CHDR_WEIGHT);

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       end0, end1;

  // Grant decision in IDLE; in PASSx the granted port is wired straight through to the MAC.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    m_tdata   = '0;
    m_tuser   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    end0      = 1'b0;
    end1      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_en) begin
          if (s0_tvalid && (!s1_tvalid || (wcnt < WMAX))) begin
            state_nxt = PASS0;
            wcnt_nxt  = (wcnt < WMAX) ? wcnt + 4'd1 : WMAX;
          end else if (s1_tvalid) begin
            state_nxt = PASS1;
            wcnt_nxt  = '0;
          end
        end
      end
      PASS0: begin
        m_tdata   = s0_tdata;
        m_tuser   = s0_tuser;
        m_tlast   = s0_tlast;
        m_tvalid  = s0_tvalid;
        s0_tready = m_tready;
        if (s0_tvalid && m_tready && s0_tlast) begin
          end0      = 1'b1;
          state_nxt = IDLE;
        end
      end
      PASS1: begin
        m_tdata   = s1_tdata;
        m_tuser   = s1_tuser;
        m_tlast   = s1_tlast;
        m_tvalid  = s1_tvalid;
        s1_tready = m_tready;
        if (s1_tvalid && m_tready && s1_tlast) begin
          end1      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idle is registered from the next state so it always matches the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      idle     <= 1'b1;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      idle  <= (state_nxt == IDLE);
      if (end0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (end1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Bench for eth_tx_pkt_arbiter: queue-driven sources, a beat scoreboard and a packet-level
// weighted round-robin reference model.
`timescale 1ns/1ps
module tb_eth_tx_pkt_arbiter;

  localparam int W     = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, arb_en;
  logic [63:0]      s0_tdata, s1_tdata, m_tdata;
  logic [3:0]       s0_tuser, s1_tuser, m_tuser;
  logic             s0_tlast, s0_tvalid, s0_tready;
  logic             s1_tlast, s1_tvalid, s1_tready;
  logic             m_tlast, m_tvalid, m_tready, idle;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  eth_tx_pkt_arbiter #(.CHDR_WEIGHT(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .s0_tdata(s0_tdata), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .idle(idle), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
    int          gap;
  } beat_t;

  beat_t q0[$], q1[$], sq0[$], sq1[$], expq[$], rxq[$];
  int    last_cyc[$];
  int    checks = 0, errors = 0, cyc = 0, stall = 0;
  int    rdy_pct = 100, pkt_serial = 0;
  int    mw = 0, mcnt0 = 0, mcnt1 = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=timeout expected=completion", tag);
  endtask

  // Queue one packet on a source; a gap stalls tvalid before a mid-packet beat only.
  task automatic applyStimulus(input int port, input int len, input logic [3:0] last_user,
                               input int gap_beat, input int gap_len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {4'(port), 12'(pkt_serial), 8'(i), 8'h5a, $urandom()};
      b.user = (i == len - 1) ? last_user : 4'd0;
      b.last = (i == len - 1);
      b.gap  = (i == gap_beat && i > 0) ? gap_len : 0;
      if (port == 0) begin q0.push_back(b); sq0.push_back(b); end
      else           begin q1.push_back(b); sq1.push_back(b); end
    end
    pkt_serial++;
  endtask

  // Packet-level reference: whole packets leave in weighted round-robin order.
  task automatic runModel();
    beat_t b;
    while (sq0.size() > 0 || sq1.size() > 0) begin
      if (sq0.size() > 0 && (sq1.size() == 0 || mw < W)) begin
        mw = (mw < W) ? mw + 1 : W;
        mcnt0++;
        do begin b = sq0.pop_front(); expq.push_back(b); end while (!b.last);
      end else begin
        mw = 0;
        mcnt1++;
        do begin b = sq1.pop_front(); expq.push_back(b); end while (!b.last);
      end
    end
  endtask

  task automatic waitRx(input int n, input string tag);
    int budget = 3000;
    while (rxq.size() < n && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) timeoutFail(tag);
  endtask

  task automatic checkScoreboard(input string tag);
    int n;
    waitRx(expq.size(), tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_beats"}, 64'(rxq.size()), 64'(expq.size()));
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_data"}, rxq[i].data, expq[i].data);
      checkOutput({tag, "_user"}, 64'(rxq[i].user), 64'(expq[i].user));
      checkOutput({tag, "_last"}, 64'(rxq[i].last), 64'(expq[i].last));
    end
    checkOutput({tag, "_cnt0"}, 64'(pkt_cnt0), 64'(mcnt0));
    checkOutput({tag, "_cnt1"}, 64'(pkt_cnt1), 64'(mcnt1));
    rxq.delete();
    expq.delete();
  endtask

  // Sources: handshakes sampled at negedge, queue advanced and new beat driven just after posedge.
  initial begin : sources
    bit fire0, fire1, rst_seen;
    int wait0, wait1;
    s0_tvalid = 0; s0_tdata = '0; s0_tuser = '0; s0_tlast = 0;
    s1_tvalid = 0; s1_tdata = '0; s1_tuser = '0; s1_tlast = 0;
    wait0 = 0; wait1 = 0;
    forever begin
      @(negedge clk);
      fire0    = s0_tvalid && s0_tready;
      fire1    = s1_tvalid && s1_tready;
      rst_seen = reset;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        q0.delete(); q1.delete(); wait0 = 0; wait1 = 0;
      end else begin
        if (fire0) begin void'(q0.pop_front()); wait0 = 0; end
        if (fire1) begin void'(q1.pop_front()); wait1 = 0; end
      end
      if (q0.size() > 0 && wait0 >= q0[0].gap) begin
        s0_tvalid = 1; s0_tdata = q0[0].data; s0_tuser = q0[0].user; s0_tlast = q0[0].last;
      end else begin
        s0_tvalid = 0; s0_tdata = '0; s0_tuser = '0; s0_tlast = 0;
        if (q0.size() > 0) wait0++;
      end
      if (q1.size() > 0 && wait1 >= q1[0].gap) begin
        s1_tvalid = 1; s1_tdata = q1[0].data; s1_tuser = q1[0].user; s1_tlast = q1[0].last;
      end else begin
        s1_tvalid = 0; s1_tdata = '0; s1_tuser = '0; s1_tlast = 0;
        if (q1.size() > 0) wait1++;
      end
    end
  end

  initial begin : sink
    m_tready = 1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (m_tvalid && m_tready) begin
        beat_t b;
        b.data = m_tdata; b.user = m_tuser; b.last = m_tlast; b.gap = 0;
        rxq.push_back(b);
        if (m_tlast) last_cyc.push_back(cyc);
      end
      if (!m_tvalid && !idle) stall++;
      if (m_tvalid && !m_tlast) checkOutput("tuser_mid", 64'(m_tuser), 64'd0);
      checkOutput("tready_excl", 64'(s0_tready & s1_tready), 64'd0);
      if (idle) begin
        checkOutput("idle_ctrl", 64'({m_tvalid, s0_tready, s1_tready, m_tlast, m_tuser}), 64'd0);
        checkOutput("idle_data", m_tdata, 64'd0);
      end
    end
  end

  initial begin : main
    int n0, n1;
    reset = 1; arb_en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_valid", 64'({m_tvalid, s0_tready, s1_tready}), 64'd0);
    checkOutput("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    checkOutput("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    @(posedge clk); #1;
    reset = 0; arb_en = 1;

    // CPU-only packets: 5 beats plus one bubble each, then single-beat packets at 2 cycles each
    @(negedge clk);
    last_cyc.delete();
    for (int p = 0; p < 3; p++) applyStimulus(1, 5, 4'($urandom_range(15)), 0, 0);
    runModel();
    checkScoreboard("cpu_only");
    checkOutput("cpu_spacing_a", 64'(last_cyc[1] - last_cyc[0]), 64'd6);
    checkOutput("cpu_spacing_b", 64'(last_cyc[2] - last_cyc[1]), 64'd6);
    last_cyc.delete();
    for (int p = 0; p < 3; p++) applyStimulus(1, 1, 4'd7, 0, 0);
    runModel();
    checkScoreboard("single_beat");
    checkOutput("single_spacing", 64'(last_cyc[2] - last_cyc[1]), 64'd2);

    // Both ports loaded: weighted order 0,0,0,0,1,0,0,0,0,1
    for (int p = 0; p < 8; p++) applyStimulus(0, 2, 4'd2, 0, 0);
    for (int p = 0; p < 2; p++) applyStimulus(1, 2, 4'd4, 0, 0);
    runModel();
    checkScoreboard("wrr");

    // Backpressure on a 9-beat CHDR packet with CPU waiting
    rdy_pct = 50;
    applyStimulus(0, 9, 4'd3, 0, 0);
    applyStimulus(1, 2, 4'd5, 0, 0);
    runModel();
    checkScoreboard("backpressure");
    rdy_pct = 100;

    // CHDR source stalls 4 cycles mid-packet; grant must hold
    stall = 0;
    applyStimulus(0, 6, 4'd1, 3, 4);
    applyStimulus(1, 2, 4'd6, 0, 0);
    runModel();
    checkScoreboard("src_stall");
    checkOutput("stall_cycles", 64'(stall), 64'd4);

    // Drain: arb_en dropped mid-packet
    applyStimulus(0, 6, 4'd8, 0, 0);
    applyStimulus(1, 2, 4'd9, 0, 0);
    runModel();
    waitRx(2, "drain_start");
    @(posedge clk); #1;
    arb_en = 0;
    waitRx(6, "drain_finish");
    repeat (5) @(negedge clk);
    checkOutput("drain_idle", 64'(idle), 64'd1);
    checkOutput("drain_valid", 64'(m_tvalid), 64'd0);
    checkOutput("drain_beats", 64'(rxq.size()), 64'd6);
    checkOutput("drain_cnt1", 64'(pkt_cnt1), 64'(mcnt1 - 1));
    @(posedge clk); #1;
    arb_en = 1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("resume_grant", 64'({m_tvalid, idle}), 64'b10);
    checkScoreboard("drain");

    // wcnt saturates at the weight rather than wrapping
    for (int p = 0; p < 17; p++) applyStimulus(0, 1, 4'd1, 0, 0);
    runModel();
    checkScoreboard("sat_fill");
    applyStimulus(0, 1, 4'd2, 0, 0);
    applyStimulus(1, 1, 4'd3, 0, 0);
    runModel();
    checkScoreboard("sat_wrr");

    // Reset mid-packet
    applyStimulus(0, 6, 4'd4, 0, 0);
    waitRx(2, "rst_mid");
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_idle", 64'(idle), 64'd1);
    checkOutput("rstmid_ctrl", 64'({m_tvalid, s0_tready, s1_tready}), 64'd0);
    checkOutput("rstmid_cnt0", 64'(pkt_cnt0), 64'd0);
    checkOutput("rstmid_cnt1", 64'(pkt_cnt1), 64'd0);
    sq0.delete(); sq1.delete(); expq.delete(); rxq.delete();
    mw = 0; mcnt0 = 0; mcnt1 = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    for (int p = 0; p < 5; p++) applyStimulus(0, 1, 4'd5, 0, 0);
    applyStimulus(1, 1, 4'd6, 0, 0);
    runModel();
    checkScoreboard("post_reset");

    // Randomised rounds
    for (int r = 0; r < 6; r++) begin
      rdy_pct = 40 + int'($urandom_range(60));
      n0 = int'($urandom_range(6));
      n1 = int'($urandom_range(3));
      for (int p = 0; p < n0; p++)
        applyStimulus(0, int'($urandom_range(8, 1)), 4'($urandom_range(15)),
                      int'($urandom_range(7)), int'($urandom_range(3)));
      for (int p = 0; p < n1; p++)
        applyStimulus(1, int'($urandom_range(8, 1)), 4'($urandom_range(15)),
                      int'($urandom_range(7)), int'($urandom_range(3)));
      runModel();
      checkScoreboard("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
